// File: rtl/pipe_router_pkg.sv
// Shared defaults and helpers for the pipe_router slice.
// Every file of the router imports this package.
package pipe_router_pkg;

  localparam int DEF_W_CHAN    = 16;
  localparam int DEF_W_SEL     = 4;
  localparam int DEF_N_IN      = 8;
  localparam int DEF_N_OUT     = 8;
  localparam int DEF_W_BLANK   = 4;
  localparam int DEF_BLANK_CYC = 3;

  // Low bit index of channel idx inside a bus of width-wide channels packed LSB first.
  function automatic int unsigned chanLo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/router_out_chan.sv
// One output channel of the router: its routing config, the settling (blank)
// counter and the registered data/valid output.
module router_out_chan
  import pipe_router_pkg::*;
#(
  parameter int   W_CHAN    = DEF_W_CHAN,
  parameter int   W_SEL     = DEF_W_SEL,
  parameter int   N_IN      = DEF_N_IN,
  parameter int   W_BLANK   = DEF_W_BLANK,
  parameter int   BLANK_CYC = DEF_BLANK_CYC,
  parameter logic ACT_INIT  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   upd_i,
  input  logic [W_SEL-1:0]       updSrc_i,
  input  logic                   updActive_i,
  input  logic                   updHold_i,
  input  logic [W_CHAN*N_IN-1:0] data_i,
  input  logic [N_IN-1:0]        dv_i,
  output logic [W_CHAN-1:0]      data_o,
  output logic                   dv_o
);

  localparam logic [W_BLANK-1:0] BlankLoad = W_BLANK'(BLANK_CYC);

  logic [W_SEL-1:0]   src_q, src_d;
  logic               active_q, active_d;
  logic               hold_q, hold_d;
  logic [W_BLANK-1:0] blank_q, blank_d;
  logic [W_CHAN-1:0]  data_q, data_d;
  logic               dv_q, dv_d;
  logic [W_CHAN-1:0]  selData;
  logic               selDv;

  // Select the routed input with a compare loop so src never indexes past N_IN.
  always_comb begin
    selData = '0;
    selDv   = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (src_q == W_SEL'(i)) begin
        selData = data_i[chanLo(i, W_CHAN) +: W_CHAN];
        selDv   = dv_i[i];
      end
    end
  end

  // Datapath decisions use the config as it stood before this edge.
  always_comb begin
    src_d    = src_q;
    active_d = active_q;
    hold_d   = hold_q;
    blank_d  = blank_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    if (blank_q != '0) blank_d = blank_q - 1'b1;
    if (upd_i) begin
      src_d    = updSrc_i;
      active_d = updActive_i;
      hold_d   = updHold_i;
      if (updSrc_i != src_q) blank_d = BlankLoad;
    end
    if (active_q && (blank_q == '0) && selDv) begin
      data_d = selData;
      dv_d   = 1'b1;
    end else if (!active_q && !hold_q) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q    <= '0;
      active_q <= ACT_INIT;
      hold_q   <= 1'b0;
      blank_q  <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
    end else begin
      src_q    <= src_d;
      active_q <= active_d;
      hold_q   <= hold_d;
      blank_q  <= blank_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
    end
  end

  assign data_o = data_q;
  assign dv_o   = dv_q;

endmodule

// File: rtl/pipe_router.sv
// Configurable N_IN x N_OUT channel router: validates single-destination
// updates and fans them out to one router_out_chan per output.
module pipe_router
  import pipe_router_pkg::*;
#(
  parameter int               W_CHAN    = DEF_W_CHAN,
  parameter int               W_SEL     = DEF_W_SEL,
  parameter int               N_IN      = DEF_N_IN,
  parameter int               N_OUT     = DEF_N_OUT,
  parameter logic [N_OUT-1:0] ACTV_INIT = {N_OUT{1'b1}},
  parameter int               W_BLANK   = DEF_W_BLANK,
  parameter int               BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [W_CHAN*N_IN-1:0]  data_packed_in,
  input  logic [N_IN-1:0]         dv_packed_in,
  input  logic [W_SEL-1:0]        src_select_in,
  input  logic [W_SEL-1:0]        dest_select_in,
  input  logic                    active_in,
  input  logic                    hold_in,
  input  logic                    update_in,
  output logic [W_CHAN*N_OUT-1:0] data_packed_out,
  output logic [N_OUT-1:0]        dv_packed_out,
  output logic                    err_out
);

  localparam logic [W_SEL:0] NInLim  = (W_SEL+1)'(N_IN);
  localparam logic [W_SEL:0] NOutLim = (W_SEL+1)'(N_OUT);

  logic updOk;
  logic err_q, err_d;

  assign updOk = ({1'b0, src_select_in} < NInLim) && ({1'b0, dest_select_in} < NOutLim);

  // Rejected updates raise err_out for exactly the following cycle.
  always_comb begin
    err_d = update_in && !updOk;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_out = err_q;

  for (genvar k = 0; k < N_OUT; k++) begin : gen_out
    localparam logic [W_SEL-1:0] DestId = W_SEL'(k);
    logic updHit;

    assign updHit = update_in && updOk && (dest_select_in == DestId);

    router_out_chan #(
      .W_CHAN   (W_CHAN),
      .W_SEL    (W_SEL),
      .N_IN     (N_IN),
      .W_BLANK  (W_BLANK),
      .BLANK_CYC(BLANK_CYC),
      .ACT_INIT (ACTV_INIT[k])
    ) u_chan (
      .clk_i      (clk_in),
      .rst_i      (rst_in),
      .upd_i      (updHit),
      .updSrc_i   (src_select_in),
      .updActive_i(active_in),
      .updHold_i  (hold_in),
      .data_i     (data_packed_in),
      .dv_i       (dv_packed_in),
      .data_o     (data_packed_out[chanLo(k, W_CHAN) +: W_CHAN]),
      .dv_o       (dv_packed_out[k])
    );
  end

endmodule
